regfile_operand_fetch: RTL and testbench

//   Operand-fetch initiator for the 2R1W 64-bit register file. Accepts decoded

---
 rtl/regfile_operand_fetch.sv | 180 ++++++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// regfile_operand_fetch
//   Operand-fetch initiator for a 2R1W register file. Accepts one decoded
//   instruction at a time and holds it while a source register has a write
//   pending in the scoreboard. Once clear, it issues the read requests, captures
//   the registered (1-cycle latency) read data and presents the operands to
//   execute with a valid/ready handshake. Writeback snooping clears hazards.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_flush                 sync abort: back to idle, scoreboard cleared
//     i_dec_*  / o_dec_ready  decoded instruction in (valid/ready)
//     o_rf_read*, o_rf_read_addr*, i_rf_read_data*   regfile read ports 0/1
//     i_wb_valid, i_wb_addr   writeback snoop (same strobe as regfile write)
//     o_op_* / i_op_ready     operands out (valid/ready)
//     o_stall_cnt             hazard-stall cycle counter
//
//   Optional feature macro: OPFETCH_STALL_CNT_EN
//     defined   -> o_stall_cnt counts S_CHECK cycles with a hazard (saturating,
//                  cleared by reset only)
//     undefined -> o_stall_cnt is constant zero
module regfile_operand_fetch #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_dec_valid,
    output logic            o_dec_ready,
    input  logic [AW-1:0]   i_dec_rs1,
    input  logic [AW-1:0]   i_dec_rs2,
    input  logic            i_dec_use_rs1,
    input  logic            i_dec_use_rs2,
    input  logic [AW-1:0]   i_dec_rd,
    input  logic            i_dec_wr_rd,
    output logic            o_rf_read0,
    output logic            o_rf_read1,
    output logic [AW-1:0]   o_rf_read_addr0,
    output logic [AW-1:0]   o_rf_read_addr1,
    input  logic [XLEN-1:0] i_rf_read_data0,
    input  logic [XLEN-1:0] i_rf_read_data1,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_addr,
    output logic            o_op_valid,
    input  logic            i_op_ready,
    output logic [XLEN-1:0] o_op_rs1_data,
    output logic [XLEN-1:0] o_op_rs2_data,
    output logic [AW-1:0]   o_op_rd,
    output logic            o_op_wr_rd,
    output logic [31:0]     o_stall_cnt
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RDWAIT, S_OUT} state_t;

    state_t            state_q;
    logic [AW-1:0]     rs1_q, rs2_q, rd_q;
    logic              use1_q, use2_q, wr_q;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              data_phase_q;   // second RDWAIT cycle: read data is on the bus
    logic              read0_q, read1_q;
    logic [AW-1:0]     addr0_q, addr1_q;
    logic              op_valid_q, op_wr_q;
    logic [XLEN-1:0]   op_rs1_q, op_rs2_q;
    logic [AW-1:0]     op_rd_q;

    logic [NREG-1:0]   wb_clr, pend_clr, pend_set;
    logic              haz;

    always_comb begin
        wb_clr = '0;
        if (i_wb_valid) wb_clr[i_wb_addr] = 1'b1;
        // A same-cycle writeback counts as clear: the regfile bypasses it.
        pend_clr = pend_q & ~wb_clr;
        haz = (use1_q & pend_clr[rs1_q]) | (use2_q & pend_clr[rs2_q]);
        pend_set = '0;
        if (state_q == S_RDWAIT && data_phase_q && wr_q && rd_q != '0)
            pend_set[rd_q] = 1'b1;
        // Set wins over a same-cycle clear; x0 can never be pending.
        pend_d = pend_clr | pend_set;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            use1_q       <= 1'b0;
            use2_q       <= 1'b0;
            wr_q         <= 1'b0;
            pend_q       <= '0;
            data_phase_q <= 1'b0;
            read0_q      <= 1'b0;
            read1_q      <= 1'b0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            op_valid_q   <= 1'b0;
            op_rs1_q     <= '0;
            op_rs2_q     <= '0;
            op_rd_q      <= '0;
            op_wr_q      <= 1'b0;
        end else if (i_flush) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            data_phase_q <= 1'b0;
            read0_q      <= 1'b0;
            read1_q      <= 1'b0;
            op_valid_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            read0_q <= 1'b0;   // read strobes are single-cycle pulses
            read1_q <= 1'b0;
            case (state_q)
                S_IDLE: if (i_dec_valid) begin
                    rs1_q   <= i_dec_rs1;
                    rs2_q   <= i_dec_rs2;
                    rd_q    <= i_dec_rd;
                    use1_q  <= i_dec_use_rs1;
                    use2_q  <= i_dec_use_rs2;
                    wr_q    <= i_dec_wr_rd;
                    state_q <= S_CHECK;
                end
                S_CHECK: if (!haz) begin
                    read0_q      <= use1_q;
                    read1_q      <= use2_q;
                    addr0_q      <= rs1_q;
                    addr1_q      <= rs2_q;
                    data_phase_q <= 1'b0;
                    state_q      <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (!data_phase_q) begin
                        data_phase_q <= 1'b1;
                    end else begin
                        data_phase_q <= 1'b0;
                        op_rs1_q     <= (use1_q && rs1_q != '0) ? i_rf_read_data0 : '0;
                        op_rs2_q     <= (use2_q && rs2_q != '0) ? i_rf_read_data1 : '0;
                        op_rd_q      <= rd_q;
                        op_wr_q      <= wr_q;
                        op_valid_q   <= 1'b1;
                        state_q      <= S_OUT;
                    end
                end
                S_OUT: if (i_op_ready) begin
                    op_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_dec_ready     = (state_q == S_IDLE);
    assign o_rf_read0      = read0_q;
    assign o_rf_read1      = read1_q;
    assign o_rf_read_addr0 = addr0_q;
    assign o_rf_read_addr1 = addr1_q;
    assign o_op_valid      = op_valid_q;
    assign o_op_rs1_data   = op_rs1_q;
    assign o_op_rs2_data   = op_rs2_q;
    assign o_op_rd         = op_rd_q;
    assign o_op_wr_rd      = op_wr_q;

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_cnt_q <= '0;
        else if (state_q == S_CHECK && haz && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_operand_fetch.sv
module tb_regfile_operand_fetch;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            dec_valid = 1'b0;
    logic            dec_ready;
    logic [AW-1:0]   dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic            dec_use1 = 1'b0, dec_use2 = 1'b0, dec_wr = 1'b0;
    logic            rf_read0, rf_read1;
    logic [AW-1:0]   rf_addr0, rf_addr1;
    logic [XLEN-1:0] rf_data0, rf_data1;
    logic            wb_valid = 1'b0;
    logic [AW-1:0]   wb_addr = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            op_valid;
    logic            op_ready = 1'b0;
    logic [XLEN-1:0] op_rs1, op_rs2;
    logic [AW-1:0]   op_rd;
    logic            op_wr;
    logic [31:0]     stall_cnt;

    always #5 clk = ~clk;

    regfile_operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
        .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
        .i_dec_use_rs1(dec_use1), .i_dec_use_rs2(dec_use2),
        .i_dec_rd(dec_rd), .i_dec_wr_rd(dec_wr),
        .o_rf_read0(rf_read0), .o_rf_read1(rf_read1),
        .o_rf_read_addr0(rf_addr0), .o_rf_read_addr1(rf_addr1),
        .i_rf_read_data0(rf_data0), .i_rf_read_data1(rf_data1),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr),
        .o_op_valid(op_valid), .i_op_ready(op_ready),
        .o_op_rs1_data(op_rs1), .o_op_rs2_data(op_rs2),
        .o_op_rd(op_rd), .o_op_wr_rd(op_wr),
        .o_stall_cnt(stall_cnt)
    );

    // Register file model: registered reads, writeback write, x0 not writable.
    // x0 storage holds garbage so the DUT's forced-zero path is exercised.
    logic [XLEN-1:0] mem [32];
    function automatic logic [XLEN-1:0] preload(input int i);
        if (i == 0) return 64'hDEAD_BEEF_DEAD_BEEF;
        if (i == 1) return 64'd5;
        if (i == 2) return 64'd7;
        return 64'h100 + XLEN'(i);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= preload(i);
            rf_data0 <= '0;
            rf_data1 <= '0;
        end else begin
            if (wb_valid && wb_addr != 0) mem[wb_addr] <= wb_data;
            if (rf_read0) rf_data0 <= mem[rf_addr0];
            if (rf_read1) rf_data1 <= mem[rf_addr1];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected operand bundle for the instruction currently in flight.
    logic            exp_armed = 1'b0;
    logic [XLEN-1:0] exp_rs1 = '0, exp_rs2 = '0;
    logic [AW-1:0]   exp_rd = '0, exp_a0 = '0, exp_a1 = '0;
    logic            exp_wr = 1'b0;
    logic            prev_rd0 = 1'b0, prev_rd1 = 1'b0;

    // Per-cycle compare against the expected transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (op_valid) begin
                chk("op_valid_expected", exp_armed, 1'b1);
                chk("op_rs1_data", op_rs1, exp_rs1);
                chk("op_rs2_data", op_rs2, exp_rs2);
                chk("op_rd", op_rd, exp_rd);
                chk("op_wr_rd", op_wr, exp_wr);
                chk("dec_ready_busy", dec_ready, 1'b0);
            end
            if (rf_read0) begin
                chk("read0_single_pulse", prev_rd0, 1'b0);
                chk("read0_addr", rf_addr0, exp_a0);
            end
            if (rf_read1) begin
                chk("read1_single_pulse", prev_rd1, 1'b0);
                chk("read1_addr", rf_addr1, exp_a1);
            end
        end
        prev_rd0 = rf_read0;
        prev_rd1 = rf_read1;
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit wr);
        int t = 0;
        while (!dec_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("dec_ready_wait", dec_ready, 1'b1);
        exp_a0 = AW'(rs1); exp_a1 = AW'(rs2);
        dec_rs1 = AW'(rs1); dec_rs2 = AW'(rs2); dec_rd = AW'(rd);
        dec_use1 = u1; dec_use2 = u2; dec_wr = wr;
        dec_valid = 1'b1;
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        exp_armed = 1'b0;
        @(negedge clk);
        chk("op_valid_after_hs", op_valid, 1'b0);
        chk("dec_ready_after_hs", dec_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    // Hazard-free fetch: pins the exact read/valid timing, optional ready hold.
    task automatic fetch(input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit wr,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                         input int hold);
        exp_rs1 = e1; exp_rs2 = e2; exp_rd = AW'(rd); exp_wr = wr; exp_armed = 1'b1;
        issue(rs1, rs2, rd, u1, u2, wr);
        @(negedge clk);
        chk("chk_no_read0", rf_read0, 1'b0);
        chk("chk_no_valid", op_valid, 1'b0);
        @(negedge clk);
        chk("read0_issue", rf_read0, u1);
        chk("read1_issue", rf_read1, u2);
        @(negedge clk);
        chk("rdwait_no_valid", op_valid, 1'b0);
        @(negedge clk);
        chk("op_valid_lat3", op_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", op_valid, 1'b1);
            chk("hold_dec_ready", dec_ready, 1'b0);
        end
        handshake();
    endtask

    task automatic wb(input int a, input logic [XLEN-1:0] d);
        wb_valid = 1'b1; wb_addr = AW'(a); wb_data = d;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    localparam logic [XLEN-1:0] HV = 64'h1234_5678_9ABC_DEF0;

    initial begin
        #3;
        @(negedge clk);
        chk("rst_dec_ready", dec_ready, 1'b1);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_read0", rf_read0, 1'b0);
        chk("rst_read1", rf_read1, 1'b0);
        chk("rst_addr0", rf_addr0, '0);
        chk("rst_op_rs1", op_rs1, '0);
        chk("rst_op_rd", op_rd, '0);
        chk("rst_stall_cnt", stall_cnt, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic fetch of preloaded x1/x2; rd=x10 becomes pending.
        fetch(1, 2, 10, 1, 1, 1, 64'd5, 64'd7, 0);
        // Clear x10, writeback to non-pending x7 is harmless; no stall expected.
        wb(10, 64'hAAAA_0000_0000_000A);
        wb(7, 64'h77);
        fetch(10, 7, 0, 1, 1, 0, 64'hAAAA_0000_0000_000A, 64'h77, 0);

        // Instr A writes x3, B reads x3 and must wait for its writeback.
        fetch(0, 0, 3, 0, 0, 1, '0, '0, 0);
        exp_rs1 = HV; exp_rs2 = '0; exp_rd = '0; exp_wr = 1'b0; exp_armed = 1'b1;
        issue(3, 4, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("haz_no_read", rf_read0, 1'b0);
            chk("haz_no_valid", op_valid, 1'b0);
            @(posedge clk); #1;
        end
        wb(3, HV);
        @(negedge clk);
        chk("haz_read_after_wb", rf_read0, 1'b1);
        chk("haz_no_read1", rf_read1, 1'b0);
`ifdef OPFETCH_STALL_CNT_EN
        chk("stall_cnt_6", stall_cnt, 32'd6);
`else
        chk("stall_cnt_off", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        chk("haz_rdwait", op_valid, 1'b0);
        @(negedge clk);
        chk("haz_op_valid", op_valid, 1'b1);
        handshake();

        // x0 source forced to 0, rd=x0 never pending, ready held low 4 cycles.
        fetch(0, 2, 0, 1, 0, 1, '0, '0, 4);
        fetch(0, 0, 0, 1, 1, 0, '0, '0, 0);

        // Flush during a hazard stall on x5.
        fetch(0, 0, 5, 0, 0, 1, '0, '0, 0);
        exp_armed = 1'b0;
        issue(5, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_pre_no_read", rf_read0, 1'b0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_op_valid", op_valid, 1'b0);
        chk("flush_dec_ready", dec_ready, 1'b1);
        chk("flush_no_read", rf_read0, 1'b0);
        @(posedge clk); #1;
        // Scoreboard cleared: x5 fetches with no stall.
        fetch(5, 0, 0, 1, 0, 0, 64'h105, '0, 0);
`ifdef OPFETCH_STALL_CNT_EN
        chk("stall_cnt_9", stall_cnt, 32'd9);
`else
        chk("stall_cnt_off_end", stall_cnt, 32'd0);
`endif

        // Asynchronous reset mid-operation.
        issue(1, 2, 9, 1, 1, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_op_valid", op_valid, 1'b0);
        chk("arst_dec_ready", dec_ready, 1'b1);
        chk("arst_read0", rf_read0, 1'b0);
        chk("arst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
